// File: rtl/button_pkg.sv
// Shared types, defaults and helpers for the button_bank debouncer slice.
package button_pkg;

    // Per-channel hold tracking after a debounced press
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    // Default system clock frequency in Hz
    localparam int SYSCLOCK_FREQ_DEFAULT = 100_000_000;

    // Bits needed to hold any count from 0 up to value
    function automatic int cnt_width(input int value);
        return $clog2(value + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and hold FSM
// producing press/release, long-press and auto-repeat pulses.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = SYSCLOCK_FREQ_DEFAULT / 200,
    parameter int LONG_PRESS_CYCLES = SYSCLOCK_FREQ_DEFAULT,
    parameter int REPEAT_CYCLES     = SYSCLOCK_FREQ_DEFAULT / 10,
    parameter int REPEAT_EN         = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic pressed,
    output logic released,
    output logic long_press,
    output logic auto_repeat
);

    localparam int DW  = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW  = cnt_width(LONG_PRESS_CYCLES);
    localparam int RW  = cnt_width(REPEAT_CYCLES);
    localparam int HW  = (LW > RW) ? LW : RW;

    generate
        if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
            $error("button_channel: *_CYCLES parameters must be >= 1");
        end
    endgenerate

    logic [1:0]    sync;
    logic          s;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    hold_state_t   state;
    logic          deb_done;
    logic          press_evt;
    logic          rel_evt;

    assign s         = sync[1];
    assign deb_done  = (s != level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign press_evt = deb_done &&  s;
    assign rel_evt   = deb_done && !s;

    // Bring the raw pin into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], pin};
        end
    end

    // Accept a new level only after it persists DEBOUNCE_CYCLES edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt     <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= 1'b0;
            released <= 1'b0;
            if (s == level) begin
                dcnt <= '0;
            end else if (deb_done) begin
                level    <= s;
                dcnt     <= '0;
                pressed  <= s;
                released <= !s;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Hold FSM: time the press for long_press, then auto-repeat; a release
    // completing on the same edge overrides any due long_press/repeat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hcnt        <= '0;
            long_press  <= 1'b0;
            auto_repeat <= 1'b0;
        end else begin
            long_press  <= 1'b0;
            auto_repeat <= 1'b0;
            if (rel_evt) begin
                state <= IDLE;
                hcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        hcnt <= '0;
                        if (press_evt) begin
                            state <= HELD;
                        end
                    end
                    HELD: begin
                        if (hcnt == HW'(LONG_PRESS_CYCLES - 1)) begin
                            long_press <= 1'b1;
                            hcnt       <= '0;
                            state      <= LONG;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    LONG: begin
                        if (REPEAT_EN == 0) begin
                            hcnt <= '0;
                        end else if (hcnt == HW'(REPEAT_CYCLES - 1)) begin
                            auto_repeat <= 1'b1;
                            hcnt        <= '0;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        hcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_bank.sv
// Bank of CHANNELS independent debounced buttons with press, release,
// long-press and auto-repeat pulses.
module button_bank
    import button_pkg::*;
#(
    parameter int CHANNELS          = 4,
    parameter int SYSCLOCK_FREQ     = SYSCLOCK_FREQ_DEFAULT,
    parameter int DEBOUNCE_CYCLES   = SYSCLOCK_FREQ / 200,
    parameter int LONG_PRESS_CYCLES = SYSCLOCK_FREQ,
    parameter int REPEAT_CYCLES     = SYSCLOCK_FREQ / 10,
    parameter int REPEAT_EN         = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] pin,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] auto_repeat
);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("button_bank: CHANNELS must be >= 1");
        end

        // One fully independent channel per pin
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            button_channel #(
                .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
                .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
                .REPEAT_CYCLES    (REPEAT_CYCLES),
                .REPEAT_EN        (REPEAT_EN)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .pin        (pin[i]),
                .level      (level[i]),
                .pressed    (pressed[i]),
                .released   (released[i]),
                .long_press (long_press[i]),
                .auto_repeat(auto_repeat[i])
            );
        end
    endgenerate

endmodule
